// File: rtl/keycode_event_decoder_pkg.sv
// Shared types and constants for the keycode GPIO reader: lane codes, event payload, scanner states.
package keycode_pkg;

    localparam int unsigned KEYCODE_W = 32;
    localparam int unsigned KEY_BYTES = 4;
    localparam int unsigned NUM_LANES = 4;
    localparam int unsigned HID_W     = 8;

    localparam logic [HID_W-1:0] KC_D        = 8'h07;
    localparam logic [HID_W-1:0] KC_F        = 8'h09;
    localparam logic [HID_W-1:0] KC_J        = 8'h0D;
    localparam logic [HID_W-1:0] KC_K        = 8'h0E;
    localparam logic [HID_W-1:0] KC_ROLLOVER = 8'h01;

    typedef logic [1:0] lane_t;

    typedef struct packed {
        logic  press;
        lane_t lane;
    } key_event_t;

    typedef enum logic {
        IDLE,
        SCAN
    } scan_state_t;

    // HID code for a piano lane (0=D, 1=F, 2=J, 3=K)
    function automatic logic [HID_W-1:0] lane_code(lane_t lane);
        logic [HID_W-1:0] code;
        case (lane)
            2'd0:    code = KC_D;
            2'd1:    code = KC_F;
            2'd2:    code = KC_J;
            default: code = KC_K;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keycode_event_decoder_if.sv
// Valid/ready event stream from the keycode decoder to the game logic.
interface keycode_event_decoder_if;
    import keycode_pkg::*;

    logic             ev_valid;
    logic             ev_ready;
    lane_t            ev_lane;
    logic             ev_press;
    logic [HID_W-1:0] ev_keycode;

    modport master (
        output ev_valid,
        output ev_lane,
        output ev_press,
        output ev_keycode,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_lane,
        input  ev_press,
        input  ev_keycode,
        output ev_ready
    );

endinterface

// File: rtl/keycode_event_decoder_event_fifo.sv
// First-word-fall-through FIFO; a push into a full FIFO succeeds only if the head pops in the same cycle.
module event_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic             full,
    output logic             drop_c
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_d;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop & valid;
    assign do_push = push & (~full | do_pop);
    assign drop_c  = push & full & ~do_pop;

    // Head is forced to zero while empty so the presented event has a defined reset value
    assign head = valid ? mem[rd_ptr] : '0;

    always_comb begin
        count_d = count;
        if (do_push && !do_pop) begin
            count_d = count + CW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= 1'b0;
            full   <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_d;
            valid <= (count_d != '0);
            full  <= (count_d == CW'(DEPTH));
        end
    end

    // Storage needs no reset; reads are gated by valid
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/keycode_event_decoder.sv
// Debounces the raw keycode GPIO word and emits per-lane press/release events through a FWFT FIFO.
module keycode_event_decoder
    import keycode_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH    = 8,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [KEYCODE_W-1:0]    keycode_i,
    keycode_event_decoder_if.master ev,
    output logic [NUM_LANES-1:0]    lane_held,
    output logic                    busy,
    output logic                    overflow
);

    localparam int unsigned CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int unsigned EV_W  = $bits(key_event_t);

    logic [KEYCODE_W-1:0] cand;
    logic [KEYCODE_W-1:0] stable;
    logic [CNT_W-1:0]     cnt;

    logic [NUM_LANES-1:0] target;
    logic                 word_valid;

    scan_state_t          state;
    scan_state_t          state_d;
    logic [NUM_LANES-1:0] pending;
    logic [NUM_LANES-1:0] pending_d;
    logic [NUM_LANES-1:0] tgt;
    logic [NUM_LANES-1:0] tgt_d;
    logic [NUM_LANES-1:0] held_d;
    lane_t                scan_lane;
    logic                 push_c;
    key_event_t           push_ev;

    logic [EV_W-1:0]      head_raw;
    key_event_t           head_ev;
    logic                 fifo_valid;
    logic                 fifo_full;
    logic                 drop_c;

    // Stability filter: a word is accepted after STABLE_CYCLES identical samples
    always_ff @(posedge clk) begin
        if (reset) begin
            cand   <= '0;
            cnt    <= '0;
            stable <= '0;
        end else if (keycode_i != cand) begin
            cand <= keycode_i;
            cnt  <= '0;
        end else if (cnt != CNT_W'(STABLE_CYCLES - 1)) begin
            cnt <= cnt + CNT_W'(1);
        end else begin
            stable <= cand;
        end
    end

    // Lane target mask; an ErrorRollOver byte anywhere invalidates the whole word
    always_comb begin
        target     = '0;
        word_valid = 1'b1;
        for (int b = 0; b < KEY_BYTES; b++) begin
            if (stable[8*b +: 8] == KC_ROLLOVER) begin
                word_valid = 1'b0;
            end
            for (int l = 0; l < NUM_LANES; l++) begin
                if (stable[8*b +: 8] == lane_code(lane_t'(l))) begin
                    target[l] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        scan_lane = '0;
        for (int l = NUM_LANES - 1; l >= 0; l--) begin
            if (pending[l]) begin
                scan_lane = lane_t'(l);
            end
        end
    end

    // Scanner next-state: one event per cycle, lowest pending lane first
    always_comb begin
        state_d   = state;
        pending_d = pending;
        tgt_d     = tgt;
        held_d    = lane_held;
        push_c    = 1'b0;
        push_ev   = '0;
        case (state)
            IDLE: begin
                if (word_valid && (target != lane_held)) begin
                    pending_d = target ^ lane_held;
                    tgt_d     = target;
                    state_d   = SCAN;
                end
            end
            SCAN: begin
                push_c               = 1'b1;
                push_ev.press        = tgt[scan_lane];
                push_ev.lane         = scan_lane;
                held_d[scan_lane]    = tgt[scan_lane];
                pending_d[scan_lane] = 1'b0;
                if (pending_d == '0) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pending   <= '0;
            tgt       <= '0;
            lane_held <= '0;
            busy      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_d;
            pending   <= pending_d;
            tgt       <= tgt_d;
            lane_held <= held_d;
            busy      <= (state_d == SCAN);
            overflow  <= overflow | drop_c;
        end
    end

    event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EV_W)
    ) u_event_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_c),
        .push_data (push_ev),
        .pop       (ev.ev_ready),
        .head      (head_raw),
        .valid     (fifo_valid),
        .full      (fifo_full),
        .drop_c    (drop_c)
    );

    assign head_ev       = key_event_t'(head_raw);
    assign ev.ev_valid   = fifo_valid;
    assign ev.ev_lane    = head_ev.lane;
    assign ev.ev_press   = head_ev.press;
    assign ev.ev_keycode = lane_code(head_ev.lane);

    // Full flag is only needed internally by the FIFO's drop rule
    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: doc/keycode_event_decoder.md
# keycode_event_decoder

Reader side of the MicroBlaze keycode GPIO. It samples the 32-bit keycode word (four HID keycode bytes) written by the USB host firmware and filters out transient values. It then turns changes in the four piano-lane keys (D, F, J, K) into discrete press/release events, which it buffers in a small FIFO for the game logic to pop with a valid/ready handshake. It sits between `keycode0_gpio` and the tile/scoring logic in the 100 MHz domain.

## Interface
- `FIFO_DEPTH`, default 8: event FIFO entries; power of two, ≥2.
- `STABLE_CYCLES`, default 4: consecutive identical samples required before a keycode word is accepted; ≥1.
- `clk` in 1: system clock, 100 MHz; the only clock. One clock; reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high; clears all state.
- `keycode_i` in 32: raw GPIO word; bytes [7:0], [15:8], [23:16] and [31:24] are independent keycodes.
- `ev_valid` out 1: FIFO non-empty; head event presented.
- `ev_ready` in 1: consumer pops the head when `ev_valid & ev_ready`.
- `ev_lane` out 2: head event lane (0=D, 1=F, 2=J, 3=K).
- `ev_press` out 1: head event type; 1 = press, 0 = release.
- `ev_keycode` out 8: HID code of the head event lane.
- `lane_held` out 4: current debounced held state per lane.
- `busy` out 1: scanner FSM in SCAN.
- `overflow` out 1: sticky; set when an event is dropped because the FIFO is full.

## Operation
- **Lane codes:** 0x07 (D), 0x09 (F), 0x0D (J), 0x0E (K).
- **Byte filtering:** byte 0x00 is ignored.
- **Rollover:** any byte equal to 0x01 (ErrorRollOver) makes the whole word invalid. An invalid word is never evaluated and `lane_held` is kept.
- **Stability filter:**
  - Registers `cand` and `cnt`.
  - If `keycode_i != cand`: `cand<=keycode_i`, `cnt<=0`.
  - Else if `cnt != STABLE_CYCLES-1`: `cnt++`.
  - Else: `stable<=cand`.
  - `cand`, `stable` and `cnt` reset to 0.
- **Target mask:** `target[l]` = 1 if any byte of `stable` equals the code for lane l. A duplicate code counts once.
- **Scanner FSM, IDLE:**
  - If `stable` is valid and `target != lane_held`: latch `pending = target ^ lane_held`, latch `tgt = target`, go to SCAN.
  - Otherwise stay in IDLE.
- **Scanner FSM, SCAN:**
  - Each cycle, take the lowest set bit l of `pending`.
  - Push `{press=tgt[l], lane=l}`.
  - Set `lane_held[l] <= tgt[l]` and clear `pending[l]`.
  - When the last bit clears, go to IDLE.
  - Changes to `stable` during SCAN are ignored until IDLE re-evaluates.
- **FIFO:** first-word-fall-through; 3-bit entries {press, lane}. `ev_keycode` is decoded combinationally from the head lane.
- **Push while full without a pop:**
  - The event is dropped and `overflow<=1`.
  - `lane_held` is still updated, so the held state always tracks the keyboard.
- **Push while full with a pop in the same cycle:** both succeed.
- **Pop while empty:** ignored.
- **Reset values:** `ev_valid=0`, `ev_lane=0`, `ev_press=0`, `ev_keycode=0x07`, `lane_held=0`, `busy=0`, `overflow=0`. The FIFO is emptied and the FSM returns to IDLE.
- **Reset mid-SCAN:** the pending events are discarded. A key still held after reset generates a fresh press event once the filter re-accepts the word.

## Timing
- Count edge 0 as the first edge that samples a new `keycode_i` value, held steady afterwards.
- `stable` updates at edge STABLE_CYCLES. With STABLE_CYCLES=1, `stable` updates at edge 1.
- The FSM enters SCAN at edge STABLE_CYCLES+1.
- The first push happens at edge STABLE_CYCLES+2; `ev_valid` is high after that edge.
- Default latency: 6 cycles from input change to the first event.
- A change of k lanes occupies SCAN for k cycles, one push per cycle.
- A glitch lasting fewer than STABLE_CYCLES samples produces no event.
- Pop latency: the next head appears the cycle after the handshake. There is no bubble when the FIFO holds ≥2 entries.
- All outputs are registered except `ev_lane`, `ev_press` and `ev_keycode`. These three are driven combinationally from the FIFO head register and read pointer.

## Structure
- `keycode_pkg`:
  - lane code constants `KC_D`, `KC_F`, `KC_J`, `KC_K`, and `KC_ROLLOVER`;
  - `lane_t` (logic [1:0]);
  - `key_event_t` packed struct {press, lane};
  - scanner state enum {IDLE, SCAN}.
- Sub-module `event_fifo`: parameterised synchronous FWFT FIFO with full/empty and a same-cycle push/pop rule, instantiated once. The filter, lane decoding and FSM stay in the top module.

## Test plan
1. Reset, then `keycode_i=0x00000007` held with ready=1: exactly one event {lane 0, press}, first valid 6 cycles after the change; `lane_held=0001`.
2. Step from `0x00000007` to `0x0E0D0900`: three events in order {0, release}, {1, press}, {2, press}, followed by {3, press}; `busy` high for 4 cycles; `lane_held=1110`.
3. Glitch to `0x00000009` for 3 cycles then back to 0: no events, `lane_held` unchanged.
4. Word `0x01010101` after `0x00000007`: no events, `lane_held` stays 0001. A following `0x00000000` gives {0, release}.
5. Hold ready=0 and force 10 lane changes with FIFO_DEPTH=8: 8 events retained, `overflow=1`, `lane_held` equals the final keyboard state. Popping with ready=1 yields the first 8 events in order.
6. Assert reset mid-SCAN while `0x0000000E` is held: all outputs return to their reset values. After release, a single {3, press} appears 6 cycles later.
